// File: rtl/cpu_pkg.sv
// Shared CPU package: ALU, memory and register-file op encodings.
package cpu_pkg;

    localparam int unsigned ALU_OP_W      = 4;
    localparam int unsigned MEM_OP_W      = 2;
    localparam int unsigned REG_FILE_OP_W = 4;

    typedef enum logic [ALU_OP_W-1:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_PASS = 4'd5
    } alu_op_e;

    typedef enum logic [MEM_OP_W-1:0] {
        MEM_NOP   = 2'd0,
        MEM_READ  = 2'd1,
        MEM_WRITE = 2'd2
    } mem_op_e;

    // Encodings 9..15 are reserved and execute as NOP.
    typedef enum logic [REG_FILE_OP_W-1:0] {
        RF_NOP   = 4'd0,
        RF_LOAD  = 4'd1,
        RF_STORE = 4'd2,
        RF_MOV   = 4'd3,
        RF_INC   = 4'd4,
        RF_DEC   = 4'd5,
        RF_CLR   = 4'd6,
        RF_PUSH  = 4'd7,
        RF_POP   = 4'd8
    } reg_file_op_e;

endpackage

// File: rtl/reg_file_stack.sv
// LIFO stack for reg_file: storage, stack pointer, full/empty flags and sticky error.
module reg_file_stack #(
    parameter int unsigned DATA_WIDTH  = 8,
    parameter int unsigned STACK_DEPTH = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  push,
    input  logic                  pop,
    input  logic [DATA_WIDTH-1:0] push_data,
    output logic [DATA_WIDTH-1:0] pop_data_c,
    output logic                  pop_ok_c,
    output logic                  stack_full,
    output logic                  stack_empty,
    output logic                  stack_error
);

    localparam int unsigned SP_W   = $clog2(STACK_DEPTH + 1);
    localparam int unsigned ADDR_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

    logic [SP_W-1:0]       sp_q, sp_d;
    logic [DATA_WIDTH-1:0] mem_q [STACK_DEPTH];
    logic [DATA_WIDTH-1:0] mem_d [STACK_DEPTH];
    logic                  error_q, error_d;
    logic                  full_c, empty_c;
    logic [ADDR_W-1:0]     push_idx_c, top_idx_c;

    assign empty_c    = (sp_q == '0);
    assign full_c     = (sp_q == SP_W'(STACK_DEPTH));
    assign push_idx_c = ADDR_W'(sp_q);
    assign top_idx_c  = ADDR_W'(sp_q - SP_W'(1));

    assign pop_ok_c    = pop && !empty_c;
    assign pop_data_c  = empty_c ? '0 : mem_q[top_idx_c];
    assign stack_empty = reset || empty_c;
    assign stack_full  = !reset && full_c;
    assign stack_error = error_q;

    always_comb begin
        sp_d    = sp_q;
        mem_d   = mem_q;
        error_d = error_q;
        if (push) begin
            if (full_c) begin
                error_d = 1'b1;
            end else begin
                mem_d[push_idx_c] = push_data;
                sp_d              = sp_q + SP_W'(1);
            end
        end else if (pop) begin
            if (empty_c) begin
                error_d = 1'b1;
            end else begin
                sp_d = sp_q - SP_W'(1);
            end
        end
    end

    // Storage is left untouched by reset; an empty sp makes old contents unreachable.
    always_ff @(posedge clock) begin
        if (reset) begin
            sp_q    <= '0;
            error_q <= 1'b0;
        end else begin
            sp_q    <= sp_d;
            mem_q   <= mem_d;
            error_q <= error_d;
        end
    end

endmodule

// File: rtl/reg_file.sv
// General register file with bus, ALU operand ports and optional stack.
// Define REG_FILE_STACK_EN to build the PUSH/POP stack; otherwise PUSH/POP are NOPs.
module reg_file
    import cpu_pkg::*;
#(
    parameter  int unsigned DATA_WIDTH  = 8,
    parameter  int unsigned REG_COUNT   = 4,
    parameter  int unsigned STACK_DEPTH = 4,
    localparam int unsigned IDX_W       = $clog2(REG_COUNT)
) (
    input  logic                  clock,
    input  logic                  reset,
    input  reg_file_op_e          op,
    input  logic [IDX_W-1:0]      dst_sel,
    input  logic [IDX_W-1:0]      src_sel,
    input  logic [DATA_WIDTH-1:0] bus_in,
    output logic [DATA_WIDTH-1:0] bus_out,
    output logic                  bus_drive,
    input  logic [IDX_W-1:0]      direct_a_sel,
    input  logic [IDX_W-1:0]      direct_b_sel,
    output logic [DATA_WIDTH-1:0] direct_a,
    output logic [DATA_WIDTH-1:0] direct_b,
    output logic                  zero,
    output logic                  stack_full,
    output logic                  stack_empty,
    output logic                  stack_error
);

    if ((REG_COUNT < 2) || (STACK_DEPTH < 1)) begin : g_bad_params
        $error("reg_file: REG_COUNT must be >= 2 and STACK_DEPTH >= 1");
    end

    logic [DATA_WIDTH-1:0] regs_q [REG_COUNT];
    logic [DATA_WIDTH-1:0] regs_d [REG_COUNT];
    logic                  zero_q, zero_d;
    logic [DATA_WIDTH-1:0] src_val_c, dst_val_c, wr_data_c;
    logic                  wr_en_c;
    logic [DATA_WIDTH-1:0] pop_data_c;
    logic                  pop_ok_c;

    function automatic logic sel_ok(input logic [IDX_W-1:0] sel);
        return 32'(sel) < REG_COUNT;
    endfunction

    // Out-of-range selects read as zero.
    assign src_val_c = sel_ok(src_sel)      ? regs_q[src_sel]      : '0;
    assign dst_val_c = sel_ok(dst_sel)      ? regs_q[dst_sel]      : '0;
    assign direct_a  = sel_ok(direct_a_sel) ? regs_q[direct_a_sel] : '0;
    assign direct_b  = sel_ok(direct_b_sel) ? regs_q[direct_b_sel] : '0;

    assign bus_drive = (op == RF_STORE) && !reset;
    assign bus_out   = bus_drive ? src_val_c : '0;
    assign zero      = zero_q;

`ifdef REG_FILE_STACK_EN
    reg_file_stack #(
        .DATA_WIDTH  (DATA_WIDTH),
        .STACK_DEPTH (STACK_DEPTH)
    ) u_stack (
        .clock       (clock),
        .reset       (reset),
        .push        (op == RF_PUSH),
        .pop         (op == RF_POP),
        .push_data   (src_val_c),
        .pop_data_c  (pop_data_c),
        .pop_ok_c    (pop_ok_c),
        .stack_full  (stack_full),
        .stack_empty (stack_empty),
        .stack_error (stack_error)
    );
`else
    assign pop_data_c  = '0;
    assign pop_ok_c    = 1'b0;
    assign stack_full  = 1'b0;
    assign stack_empty = 1'b1;
    assign stack_error = 1'b0;
`endif

    // Select the write value per op, then commit it to a valid destination.
    always_comb begin
        regs_d    = regs_q;
        zero_d    = zero_q;
        wr_en_c   = 1'b0;
        wr_data_c = '0;
        case (op)
            RF_LOAD: begin wr_en_c = 1'b1;     wr_data_c = bus_in;                        end
            RF_MOV:  begin wr_en_c = 1'b1;     wr_data_c = src_val_c;                     end
            RF_INC:  begin wr_en_c = 1'b1;     wr_data_c = dst_val_c + DATA_WIDTH'(1);    end
            RF_DEC:  begin wr_en_c = 1'b1;     wr_data_c = dst_val_c - DATA_WIDTH'(1);    end
            RF_CLR:  begin wr_en_c = 1'b1;     wr_data_c = '0;                            end
            RF_POP:  begin wr_en_c = pop_ok_c; wr_data_c = pop_data_c;                    end
            default: ;
        endcase
        if (wr_en_c && sel_ok(dst_sel)) begin
            regs_d[dst_sel] = wr_data_c;
            zero_d          = (wr_data_c == '0);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            regs_q <= '{default: '0};
            zero_q <= 1'b1;
        end else begin
            regs_q <= regs_d;
            zero_q <= zero_d;
        end
    end

endmodule

// File: tb/tb_reg_file.sv
// Self-checking bench for reg_file: array/queue reference model plus directed literal checks.
module tb_reg_file;
    import cpu_pkg::*;

    localparam int unsigned DW = 8;
    localparam int unsigned RC = 4;
    localparam int unsigned SD = 4;
    localparam int unsigned IW = 2;

    logic          clock = 1'b0;
    logic          reset;
    reg_file_op_e  op;
    logic [IW-1:0] dst_sel, src_sel, da_sel, db_sel;
    logic [DW-1:0] bus_in;
    logic [DW-1:0] bus_out, direct_a, direct_b;
    logic          bus_drive, zero, stack_full, stack_empty, stack_error;

    reg_file #(.DATA_WIDTH(DW), .REG_COUNT(RC), .STACK_DEPTH(SD)) dut (
        .clock        (clock),
        .reset        (reset),
        .op           (op),
        .dst_sel      (dst_sel),
        .src_sel      (src_sel),
        .bus_in       (bus_in),
        .bus_out      (bus_out),
        .bus_drive    (bus_drive),
        .direct_a_sel (da_sel),
        .direct_b_sel (db_sel),
        .direct_a     (direct_a),
        .direct_b     (direct_b),
        .zero         (zero),
        .stack_full   (stack_full),
        .stack_empty  (stack_empty),
        .stack_error  (stack_error)
    );

    always #5 clock = ~clock;

    int errors = 0;
    int checks = 0;
    bit cmp_en = 1'b0;

    int m_regs [RC];
    bit m_zero;
    bit m_err;
    int m_stk [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int mread(input int i);
        return (i < int'(RC)) ? m_regs[i] : 0;
    endfunction

    function automatic void mwrite(input int d, input int v);
        if (d < int'(RC)) begin
            m_regs[d] = v;
            m_zero    = (v == 0);
        end
    endfunction

    // Reference behaviour applied at each rising edge from the inputs present there.
    task automatic model_apply();
        int d, s;
        d = int'(dst_sel);
        s = int'(src_sel);
        if (reset) begin
            foreach (m_regs[i]) m_regs[i] = 0;
            m_zero = 1'b1;
            m_err  = 1'b0;
            m_stk.delete();
        end else begin
            case (op)
                RF_LOAD: mwrite(d, int'(bus_in));
                RF_MOV:  mwrite(d, mread(s));
                RF_INC:  mwrite(d, (mread(d) + 1) % 256);
                RF_DEC:  mwrite(d, (mread(d) + 255) % 256);
                RF_CLR:  mwrite(d, 0);
`ifdef REG_FILE_STACK_EN
                RF_PUSH: if (m_stk.size() == int'(SD)) m_err = 1'b1;
                         else m_stk.push_back(mread(s));
                RF_POP:  if (m_stk.size() == 0) m_err = 1'b1;
                         else mwrite(d, m_stk.pop_back());
`endif
                default: ;
            endcase
        end
    endtask

    // Every-cycle comparison of all outputs against the model.
    always @(negedge clock) begin
        if (cmp_en) begin
            bit exp_drive;
            exp_drive = (op == RF_STORE) && !reset;
            chk("direct_a", direct_a, mread(int'(da_sel)));
            chk("direct_b", direct_b, mread(int'(db_sel)));
            chk("bus_drive", bus_drive, exp_drive);
            chk("bus_out", bus_out, exp_drive ? mread(int'(src_sel)) : 0);
            chk("zero", zero, m_zero);
`ifdef REG_FILE_STACK_EN
            chk("stack_empty", stack_empty, reset || (m_stk.size() == 0));
            chk("stack_full", stack_full, !reset && (m_stk.size() == int'(SD)));
            chk("stack_error", stack_error, m_err);
`else
            chk("stack_empty", stack_empty, 1);
            chk("stack_full", stack_full, 0);
            chk("stack_error", stack_error, 0);
`endif
        end
    end

    task automatic drive(input reg_file_op_e o, input int d, input int s, input int b);
        op      = o;
        dst_sel = IW'(d);
        src_sel = IW'(s);
        bus_in  = DW'(b);
    endtask

    task automatic half();
        @(negedge clock);
    endtask

    task automatic fin();
        @(posedge clock);
        model_apply();
        #1;
    endtask

    task automatic step(input reg_file_op_e o, input int d, input int s, input int b);
        drive(o, d, s, b);
        half();
        fin();
    endtask

    initial begin
        reset = 1'b1;
        da_sel = '0;
        db_sel = '0;
        drive(RF_STORE, 0, 0, 0);
        fin();
        cmp_en = 1'b1;

        // Reset held while a PUSH is presented.
        drive(RF_PUSH, 0, 0, 0);
        half();
        chk("rst_bus_drive", bus_drive, 0);
        chk("rst_empty", stack_empty, 1);
        chk("rst_full", stack_full, 0);
        fin();
        reset = 1'b0;

        drive(RF_NOP, 0, 0, 0);
        half();
        chk("rst_zero", zero, 1);
        chk("rst_r0", direct_a, 0);
        fin();

        step(RF_LOAD, 2, 0, 'h5A);
        drive(RF_STORE, 0, 2, 0);
        half();
        chk("store_bus", bus_out, 'h5A);
        chk("store_drive", bus_drive, 1);
        fin();
        drive(RF_NOP, 0, 2, 0);
        half();
        chk("after_store_bus", bus_out, 0);
        chk("after_store_drive", bus_drive, 0);
        fin();

        step(RF_CLR, 1, 0, 0);
        step(RF_DEC, 1, 0, 0);
        da_sel = 2'd1;
        drive(RF_NOP, 0, 0, 0);
        half();
        chk("dec_wrap", direct_a, 'hFF);
        chk("dec_zero", zero, 0);
        fin();
        step(RF_INC, 1, 0, 0);
        drive(RF_NOP, 0, 0, 0);
        half();
        chk("inc_wrap", direct_a, 'h00);
        chk("inc_zero", zero, 1);
        fin();

        step(RF_LOAD, 0, 0, 'h11);
        step(RF_MOV, 3, 0, 0);
        da_sel = 2'd3;
        db_sel = 2'd0;
        drive(RF_NOP, 0, 0, 0);
        half();
        chk("mov_a", direct_a, 'h11);
        chk("mov_b", direct_b, 'h11);
        fin();

        step(RF_MOV, 2, 2, 0);
        da_sel = 2'd2;
        db_sel = 2'd2;
        drive(RF_NOP, 0, 0, 0);
        half();
        chk("mov_self", direct_a, 'h5A);
        chk("mov_self_b", direct_b, 'h5A);
        chk("mov_self_zero", zero, 0);
        fin();

        step(reg_file_op_e'(4'hF), 2, 2, 'h00);
        drive(RF_NOP, 0, 0, 0);
        half();
        chk("reserved_op", direct_a, 'h5A);
        fin();

        step(RF_LOAD, 3, 0, 'h00);
        drive(RF_NOP, 0, 0, 0);
        half();
        chk("load_zero", zero, 1);
        fin();

`ifdef REG_FILE_STACK_EN
        for (int v = 1; v <= 4; v++) begin
            step(RF_LOAD, 1, 0, v);
            step(RF_PUSH, 0, 1, 0);
        end
        drive(RF_NOP, 0, 0, 0);
        half();
        chk("push_full", stack_full, 1);
        chk("push_full_err", stack_error, 0);
        fin();
        step(RF_PUSH, 0, 1, 0);
        drive(RF_NOP, 0, 0, 0);
        half();
        chk("overflow_err", stack_error, 1);
        chk("overflow_full", stack_full, 1);
        fin();
        da_sel = 2'd0;
        for (int k = 0; k < 4; k++) begin
            step(RF_POP, 0, 0, 0);
            drive(RF_NOP, 0, 0, 0);
            half();
            chk("pop_val", direct_a, 4 - k);
            fin();
        end
        drive(RF_NOP, 0, 0, 0);
        half();
        chk("pop_empty", stack_empty, 1);
        fin();

        step(RF_LOAD, 1, 0, 'h77);
        step(RF_PUSH, 0, 1, 0);
        reset = 1'b1;
        step(RF_PUSH, 0, 1, 0);
        reset = 1'b0;
        da_sel = 2'd1;
        drive(RF_NOP, 0, 0, 0);
        half();
        chk("rst_push_empty", stack_empty, 1);
        chk("rst_push_err", stack_error, 0);
        chk("rst_push_r1", direct_a, 0);
        fin();

        step(RF_LOAD, 2, 0, 'h33);
        step(RF_POP, 2, 0, 0);
        da_sel = 2'd2;
        drive(RF_NOP, 0, 0, 0);
        half();
        chk("underflow_err", stack_error, 1);
        chk("underflow_dst", direct_a, 'h33);
        fin();
`else
        da_sel = 2'd0;
        step(RF_PUSH, 0, 0, 0);
        drive(RF_NOP, 0, 0, 0);
        half();
        chk("nostack_empty", stack_empty, 1);
        chk("nostack_err", stack_error, 0);
        chk("nostack_r0", direct_a, 'h11);
        fin();
        step(RF_POP, 0, 0, 0);
        drive(RF_NOP, 0, 0, 0);
        half();
        chk("nostack_pop_r0", direct_a, 'h11);
        chk("nostack_pop_err", stack_error, 0);
        fin();
`endif

        drive(RF_NOP, 0, 0, 0);
        half();
        fin();
        cmp_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/reg_file.md
REG_FILE -- requirements
Module: reg_file

Interface
REQ-001 Parameter DATA_WIDTH, default 8, sets the width of each register, bus port and direct port.
REQ-002 Parameter REG_COUNT, default 4, sets the number of general registers; must be at least 2.
REQ-003 Parameter STACK_DEPTH, default 4, sets the number of stack entries; must be at least 1.
REQ-004 The block SHALL use one clock; reset is synchronous and active-high.
REQ-005 clock  in  1  rising-edge clock.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 op  in  4  reg_file_op_e: NOP, LOAD, STORE, MOV, INC, DEC, CLR, PUSH, POP.
REQ-008 dst_sel  in  IDX_W=$clog2(REG_COUNT)  destination register index.
REQ-009 src_sel  in  IDX_W  source register index.
REQ-010 bus_in  in  DATA_WIDTH  shared bus value.
REQ-011 bus_out  out  DATA_WIDTH  value the block drives onto the bus.
REQ-012 bus_drive  out  1  high while bus_out is valid for the bus.
REQ-013 direct_a_sel, direct_b_sel  in  IDX_W  ALU operand indices.
REQ-014 direct_a, direct_b  out  DATA_WIDTH  ALU operand values.
REQ-015 zero  out  1  registered: the last written register value was zero.
REQ-016 stack_full, stack_empty, stack_error  out  1 each  stack status.

Function
REQ-017 LOAD SHALL write bus_in to reg[dst_sel] at the rising edge; direct ports show the new value from the next cycle.
REQ-018 STORE SHALL combinationally drive bus_out=reg[src_sel] and bus_drive=1 in the same cycle; in all other cycles bus_out=0 and bus_drive=0.
REQ-019 MOV SHALL write reg[src_sel] to reg[dst_sel]; when dst_sel==src_sel the value does not change.
REQ-020 INC and DEC SHALL update reg[dst_sel] modulo 2^DATA_WIDTH: INC of all-ones gives 0, DEC of 0 gives all-ones.
REQ-021 CLR SHALL write 0 to reg[dst_sel].
REQ-022 direct_a and direct_b SHALL be combinational reads of the current register contents; both indices may be equal.
REQ-023 A select value >= REG_COUNT SHALL suppress the write and read as 0.
REQ-024 zero SHALL update with (written value == 0) on LOAD, MOV, INC, DEC, CLR and successful POP, and hold its value otherwise.
REQ-025 PUSH SHALL copy reg[src_sel] to stack[sp] and increment sp by one.
REQ-026 POP SHALL decrement sp by one and write stack[sp-1] to reg[dst_sel].
REQ-027 stack_empty SHALL be high when sp==0; stack_full SHALL be high when sp==STACK_DEPTH; both are derived from registered sp.
REQ-028 PUSH while full and POP while empty SHALL leave sp, the stack and the registers unchanged and set stack_error.
REQ-029 stack_error SHALL be sticky and clear only on reset.
REQ-030 Exactly one op executes per cycle; reg_file_op_e encodings not listed SHALL behave as NOP.

Reset
REQ-031 While reset is high at a rising edge, all registers SHALL be cleared to 0, sp=0, zero=1 and stack_error=0; the op input is ignored in that cycle.
REQ-032 During reset cycles, bus_drive SHALL be 0, stack_empty=1 and stack_full=0.
REQ-033 Reset during a PUSH or POP SHALL win; no stack or register update occurs.

Configuration
REQ-034 With REG_FILE_STACK_EN defined, the stack (REQ-025..029) SHALL be implemented.
REQ-035 Without REG_FILE_STACK_EN, PUSH and POP SHALL act as NOP, no stack storage is built, stack_full=0, stack_empty=1 and stack_error=0 constantly; the ports remain present.

Structure
REQ-036 reg_file_op_e and its 4-bit encoding SHALL live in the shared CPU package cpu_pkg, next to the existing ALU and memory op enums.
REQ-037 The stack (storage, sp, flags, error) SHALL be a sub-module reg_file_stack, instantiated only under REG_FILE_STACK_EN.

Verification
REQ-038 LOAD 0x5A to r2, then STORE r2 -> bus_out=0x5A, bus_drive=1 in the STORE cycle, and 0/0 in the next cycle.
REQ-039 CLR r1, then DEC r1 -> r1=0xFF, zero=0; INC r1 -> r1=0x00, zero=1.
REQ-040 LOAD r0=0x11, MOV r3<-r0, direct_a_sel=3, direct_b_sel=0 -> direct_a=direct_b=0x11.
REQ-041 STACK_EN, depth 4: push 0x01..0x04 -> full=1; a 5th PUSH -> error=1, sp holds; POP x4 into r0 -> 0x04, 0x03, 0x02, 0x01, then empty=1.
REQ-042 POP on empty -> error=1, dst unchanged; reset asserted on a PUSH cycle -> sp=0, error=0, all registers 0.
REQ-043 Without the macro: PUSH r0 -> stack_empty stays 1, stack_error stays 0, registers unchanged.
